// File: rtl/nou_index_vector_pkg.sv
// Shared types and sizing helpers for the index vector builder.
package nou_index_vector_pkg;

  typedef enum logic {ACCUM, HOLD} ivb_state_t;

  // Bits needed to hold a population count of 0..n inclusive.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/index_to_onehot_decoder.sv
// Decodes a bit index into a one-hot mask, flagging indices outside the mask.
module index_to_onehot_decoder #(
  parameter int unsigned VECTOR_LENGTH   = 8,
  parameter int unsigned MAX_INPUT_WIDTH = 16
) (
  input  logic [MAX_INPUT_WIDTH-1:0] index,
  output logic [VECTOR_LENGTH-1:0]   mask,
  output logic                       in_range
);

  // Full-width compare so high index bits can never alias onto low mask bits.
  always_comb begin
    in_range = (index < MAX_INPUT_WIDTH'(VECTOR_LENGTH));
    mask     = '0;
    for (int unsigned i = 0; i < VECTOR_LENGTH; i++) begin
      mask[i] = in_range && (index == MAX_INPUT_WIDTH'(i));
    end
  end

endmodule

// File: rtl/index_vector_builder.sv
// Builds a selection mask from a stream of bit indices, one frame at a time.
module index_vector_builder
  import nou_index_vector_pkg::*;
#(
  parameter int unsigned VECTOR_LENGTH   = 8,
  parameter int unsigned MAX_INPUT_WIDTH = 16,
  localparam int unsigned COUNT_WIDTH    = count_width(VECTOR_LENGTH)
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic                       clear_in,
  input  logic [MAX_INPUT_WIDTH-1:0] index_in,
  input  logic                       index_valid_in,
  input  logic                       index_last_in,
  output logic                       index_ready_out,
  output logic [VECTOR_LENGTH-1:0]   vector_out,
  output logic [COUNT_WIDTH-1:0]     set_count_out,
  output logic                       out_of_range_out,
  output logic                       vector_valid_out,
  input  logic                       vector_ready_in
);

  ivb_state_t               state_q, state_d;
  logic [VECTOR_LENGTH-1:0] acc_q, acc_d;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                     oor_q, oor_d;
  logic [VECTOR_LENGTH-1:0] dec_mask;
  logic                     dec_in_range;

  index_to_onehot_decoder #(
    .VECTOR_LENGTH  (VECTOR_LENGTH),
    .MAX_INPUT_WIDTH(MAX_INPUT_WIDTH)
  ) u_decoder (
    .index   (index_in),
    .mask    (dec_mask),
    .in_range(dec_in_range)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      oor_q   <= oor_d;
    end
  end

  // Next frame state: clear beats any handshake; HOLD waits for the consumer.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    oor_d   = oor_q;
    if (clear_in) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      oor_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (index_valid_in) begin
            if (dec_in_range) begin
              acc_d = acc_q | dec_mask;
              if ((dec_mask & acc_q) == '0) cnt_d = cnt_q + COUNT_WIDTH'(1);
            end else begin
              oor_d = 1'b1;
            end
            if (index_last_in) state_d = HOLD;
          end
        end
        HOLD: begin
          if (vector_ready_in) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            oor_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  assign index_ready_out  = (state_q == ACCUM) && !reset_in;
  assign vector_valid_out = (state_q == HOLD);
  assign vector_out       = acc_q;
  assign set_count_out    = cnt_q;
  assign out_of_range_out = oor_q;

endmodule

// File: tb/tb_index_vector_builder.sv
// Directed and random checks of index_vector_builder against a frame-list model.
module tb_index_vector_builder;

  localparam int unsigned VL = 8;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = $clog2(VL + 1);

  logic          clk_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          clear_in = 1'b0;
  logic [IW-1:0] index_in = '0;
  logic          index_valid_in = 1'b0;
  logic          index_last_in = 1'b0;
  logic          index_ready_out;
  logic [VL-1:0] vector_out;
  logic [CW-1:0] set_count_out;
  logic          out_of_range_out;
  logic          vector_valid_out;
  logic          vector_ready_in = 1'b0;

  index_vector_builder #(.VECTOR_LENGTH(VL), .MAX_INPUT_WIDTH(IW)) dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .clear_in        (clear_in),
    .index_in        (index_in),
    .index_valid_in  (index_valid_in),
    .index_last_in   (index_last_in),
    .index_ready_out (index_ready_out),
    .vector_out      (vector_out),
    .set_count_out   (set_count_out),
    .out_of_range_out(out_of_range_out),
    .vector_valid_out(vector_valid_out),
    .vector_ready_in (vector_ready_in)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Model: the list of indices accepted in the current frame, and whether it is done.
  int unsigned frame_q[$];
  bit          frame_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VL-1:0] exp_mask();
    logic [VL-1:0] m = '0;
    foreach (frame_q[i]) if (frame_q[i] < VL) m[frame_q[i]] = 1'b1;
    return m;
  endfunction

  function automatic int unsigned exp_count();
    int unsigned n = 0;
    for (int unsigned b = 0; b < VL; b++) begin
      bit seen = 1'b0;
      foreach (frame_q[i]) if (frame_q[i] == b) seen = 1'b1;
      if (seen) n++;
    end
    return n;
  endfunction

  function automatic bit exp_oor();
    foreach (frame_q[i]) if (frame_q[i] >= VL) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".vector"}, 32'(vector_out), 32'(exp_mask()));
    chk({tag, ".count"}, 32'(set_count_out), exp_count());
    chk({tag, ".oor"}, 32'(out_of_range_out), 32'(exp_oor()));
    chk({tag, ".valid"}, 32'(vector_valid_out), 32'(frame_done));
    chk({tag, ".ready"}, 32'(index_ready_out), 32'(!frame_done && !reset_in));
  endtask

  // Drive one cycle at the falling edge, update the model at the rising edge,
  // then check outputs at the next falling edge.
  task automatic step(input string tag, input bit v, input logic [IW-1:0] idx, input bit last,
                      input bit vr, input bit clr, input bit rst);
    index_valid_in  = v;
    index_in        = idx;
    index_last_in   = last;
    vector_ready_in = vr;
    clear_in        = clr;
    reset_in        = rst;
    @(posedge clk_in);
    if (rst || clr) begin
      frame_q.delete();
      frame_done = 1'b0;
    end else if (!frame_done) begin
      if (v) begin
        frame_q.push_back(int'(idx));
        if (last) frame_done = 1'b1;
      end
    end else if (vr) begin
      frame_q.delete();
      frame_done = 1'b0;
    end
    @(negedge clk_in);
    check_all(tag);
  endtask

  initial begin
    @(negedge clk_in);
    step("reset", 0, '0, 0, 0, 0, 1);
    chk("reset.ready_forced_low", 32'(index_ready_out), 32'd0);
    step("idle", 0, '0, 0, 0, 0, 0);

    step("f1.i1", 1, 16'd1, 0, 1, 0, 0);
    step("f1.i4", 1, 16'd4, 0, 1, 0, 0);
    step("f1.i6", 1, 16'd6, 1, 1, 0, 0);
    chk("f1.vector_lit", 32'(vector_out), 32'h52);
    chk("f1.count_lit", 32'(set_count_out), 32'd3);
    step("f1.take", 0, '0, 0, 1, 0, 0);

    step("f2.a", 1, 16'd3, 0, 0, 0, 0);
    step("f2.b", 1, 16'd3, 0, 0, 0, 0);
    step("f2.c", 1, 16'd3, 1, 0, 0, 0);
    chk("f2.vector_lit", 32'(vector_out), 32'h08);
    chk("f2.count_lit", 32'(set_count_out), 32'd1);
    step("f2.take", 0, '0, 0, 1, 0, 0);

    step("f3.a", 1, 16'd2, 0, 0, 0, 0);
    step("f3.b", 1, 16'd9, 0, 0, 0, 0);
    step("f3.c", 1, 16'h8002, 1, 0, 0, 0);
    chk("f3.vector_lit", 32'(vector_out), 32'h04);
    chk("f3.oor_lit", 32'(out_of_range_out), 32'd1);
    step("f3.take", 0, '0, 0, 1, 0, 0);

    for (int i = 0; i < 8; i++) step("f4.fill", 1, IW'(i), i == 7, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("f4.stall", 1, 16'd5, 0, 0, 0, 0);
    chk("f4.vector_lit", 32'(vector_out), 32'hFF);
    chk("f4.count_lit", 32'(set_count_out), 32'd8);
    step("f4.take", 1, 16'd5, 0, 1, 0, 0);
    step("f4.next5", 1, 16'd5, 1, 0, 0, 0);
    chk("f4.next5_lit", 32'(vector_out), 32'h20);
    step("f4.take2", 0, '0, 0, 1, 0, 0);

    step("f5.a", 1, 16'd0, 0, 0, 0, 0);
    step("f5.b", 1, 16'd7, 0, 0, 0, 0);
    step("f5.clr", 1, 16'd1, 1, 0, 1, 0);
    step("f5.c", 1, 16'd2, 1, 0, 0, 0);
    chk("f5.vector_lit", 32'(vector_out), 32'h04);
    step("f5.take", 0, '0, 0, 1, 0, 0);

    step("empty", 1, 16'd200, 1, 0, 0, 0);
    chk("empty.vector_lit", 32'(vector_out), 32'h00);
    chk("empty.oor_lit", 32'(out_of_range_out), 32'd1);
    step("empty.clear_in_hold", 0, '0, 0, 1, 1, 0);

    step("r1.a", 1, 16'd1, 1, 0, 0, 0);
    step("r1.rst_hold", 0, '0, 0, 0, 0, 1);
    step("r1.after", 0, '0, 0, 0, 0, 0);
    step("r2.a", 1, 16'd4, 0, 0, 0, 0);
    step("r2.rst_last", 1, 16'd6, 1, 0, 0, 1);
    step("r2.after", 0, '0, 0, 0, 0, 0);
    chk("r2.no_valid", 32'(vector_valid_out), 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [IW-1:0] idx;
      idx = ($urandom_range(0, 7) == 0) ? IW'($urandom) : IW'($urandom_range(0, VL - 1));
      step("rand", $urandom_range(0, 3) != 0, idx, $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
